// File: rtl/cfg_chain_loader_if.sv
// Byte-stream handshake between the boot front-end (master) and the chain loader (slave).
interface cfg_chain_loader_if;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;

    modport master (output IN_DATA, output IN_VALID, input IN_READY);
    modport slave  (input IN_DATA, input IN_VALID, output IN_READY);
endinterface

// File: rtl/cfg_chain_loader.sv
// Serialises a host byte stream LSB-first onto the fabric configuration chain,
// then pulses the chain latch strobe once CHAIN_LEN bits have been shifted.
module cfg_chain_loader #(
    parameter int CHAIN_LEN    = 288,
    parameter int LATCH_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              ABORT,
    cfg_chain_loader_if.slave host,
    output logic              CFG_DO,
    output logic              CFG_SHIFT,
    output logic              CFG_LATCH,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);
    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int BL_W   = $clog2(CHAIN_LEN + 1);
    localparam int BY_W   = $clog2(NBYTES + 1);
    localparam int LC_W   = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [BL_W-1:0]   bits_q, bits_d, bits_after;
    logic [BY_W-1:0]   bytes_q, bytes_d;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [LC_W-1:0]   latch_q, latch_d;
    logic              err_q, err_d;
    logic              shift_en, ready, xfer;

    function automatic logic [BL_W-1:0] bits_dec(input logic [BL_W-1:0] v);
        return (v == '0) ? v : v - BL_W'(1);
    endfunction

    function automatic logic [BY_W-1:0] bytes_dec(input logic [BY_W-1:0] v);
        return (v == '0) ? v : v - BY_W'(1);
    endfunction

    // Valid bits a freshly loaded byte carries: the tail byte may be partial.
    function automatic logic [3:0] fill_count(input logic [BL_W-1:0] v);
        if (32'(v) >= 32'd8) return 4'd8;
        return 4'(v);
    endfunction

    assign shift_en   = (state_q == S_SHIFT) && !ABORT && (bcnt_q != 4'd0);
    assign ready      = (state_q == S_SHIFT) && !ABORT && (bcnt_q <= 4'd1) && (bytes_q != '0);
    assign xfer       = ready && host.IN_VALID;
    assign bits_after = shift_en ? bits_dec(bits_q) : bits_q;

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        bytes_d = bytes_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        latch_d = latch_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (START && !ABORT) begin
                    state_d = S_SHIFT;
                    err_d   = 1'b0;
                    bits_d  = BL_W'(CHAIN_LEN);
                    bytes_d = BY_W'(NBYTES);
                    bcnt_d  = 4'd0;
                end
            end
            S_SHIFT: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    bits_d  = '0;
                    bytes_d = '0;
                    bcnt_d  = 4'd0;
                    shreg_d = 8'd0;
                end else begin
                    if (shift_en) begin
                        shreg_d = shreg_q >> 1;
                        bcnt_d  = bcnt_q - 4'd1;
                        bits_d  = bits_after;
                    end
                    // A new byte may land in the same cycle the last buffered bit leaves.
                    if (xfer) begin
                        shreg_d = host.IN_DATA;
                        bcnt_d  = fill_count(bits_after);
                        bytes_d = bytes_dec(bytes_q);
                    end
                    if (shift_en && bits_after == '0) begin
                        state_d = S_LATCH;
                        latch_d = LC_W'(LATCH_CYCLES);
                    end
                end
            end
            S_LATCH: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    latch_d = '0;
                end else if (latch_q <= LC_W'(1)) begin
                    state_d = S_DONE;
                    latch_d = '0;
                end else begin
                    latch_d = latch_q - LC_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            bits_q  <= '0;
            bytes_q <= '0;
            bcnt_q  <= 4'd0;
            shreg_q <= 8'd0;
            latch_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            bytes_q <= bytes_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            latch_q <= latch_d;
            err_q   <= err_d;
        end
    end

    assign host.IN_READY = ready;
    assign CFG_SHIFT     = shift_en;
    assign CFG_DO        = shift_en & shreg_q[0];
    assign CFG_LATCH     = (state_q == S_LATCH) && !ABORT;
    assign BUSY          = (state_q == S_SHIFT) || (state_q == S_LATCH);
    assign DONE          = (state_q == S_DONE);
    assign ERR           = err_q;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: table-driven cycle vectors on a 12-bit chain,
// plus hand-written reset and 8-bit/1-cycle-latch sequences.
module tb_cfg_chain_loader;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic a_start = 0, a_abort = 0;
    logic a_do, a_shift, a_latch, a_busy, a_done, a_err;
    logic b_start = 0, b_abort = 0;
    logic b_do, b_shift, b_latch, b_busy, b_done, b_err;

    cfg_chain_loader_if ifa ();
    cfg_chain_loader_if ifb ();

    cfg_chain_loader #(.CHAIN_LEN(12), .LATCH_CYCLES(2)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .START(a_start), .ABORT(a_abort), .host(ifa),
        .CFG_DO(a_do), .CFG_SHIFT(a_shift), .CFG_LATCH(a_latch),
        .BUSY(a_busy), .DONE(a_done), .ERR(a_err));

    cfg_chain_loader #(.CHAIN_LEN(8), .LATCH_CYCLES(1)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .START(b_start), .ABORT(b_abort), .host(ifb),
        .CFG_DO(b_do), .CFG_SHIFT(b_shift), .CFG_LATCH(b_latch),
        .BUSY(b_busy), .DONE(b_done), .ERR(b_err));

    // Output vector order: {shift, do, ready, latch, busy, done, err}
    wire [6:0] a_out = {a_shift, a_do, ifa.IN_READY, a_latch, a_busy, a_done, a_err};
    wire [6:0] b_out = {b_shift, b_do, ifb.IN_READY, b_latch, b_busy, b_done, b_err};

    typedef struct {
        bit         start;
        bit         abort;
        bit         valid;
        logic [7:0] data;
        logic [6:0] exp;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {shift,do,ready,latch,busy,done,err}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic row(input bit st, input bit ab, input bit v, input logic [7:0] d, input logic [6:0] e);
        vec_t r;
        r.start = st; r.abort = ab; r.valid = v; r.data = d; r.exp = e;
        vq.push_back(r);
    endtask

    // Full 12-bit load of 0xA5,0x03 with continuous IN_VALID; optional START pulses mid-SHIFT and mid-LATCH.
    task automatic add_full_load(input logic [6:0] first_out, input bit start_mid);
        row(1, 0, 0, 8'h00, first_out);
        row(0, 0, 1, 8'hA5, 7'b0010100);
        row(0, 0, 1, 8'h03, 7'b1100100);
        row(0, 0, 1, 8'h03, 7'b1000100);
        row(0, 0, 1, 8'h03, 7'b1100100);
        row(start_mid, 0, 1, 8'h03, 7'b1000100);
        row(0, 0, 1, 8'h03, 7'b1000100);
        row(0, 0, 1, 8'h03, 7'b1100100);
        row(0, 0, 1, 8'h03, 7'b1000100);
        row(0, 0, 1, 8'h03, 7'b1110100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(start_mid, 0, 0, 8'h00, 7'b0001100);
        row(0, 0, 0, 8'h00, 7'b0001100);
        row(0, 0, 0, 8'h00, 7'b0000010);
    endtask

    task automatic run_table(input string tname);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge CLK); #1;
            a_start = vq[i].start; a_abort = vq[i].abort;
            ifa.IN_VALID = vq[i].valid; ifa.IN_DATA = vq[i].data;
            @(negedge CLK);
            chk($sformatf("%s[%0d]", tname, i), a_out, vq[i].exp);
        end
        @(posedge CLK); #1;
        a_start = 0; a_abort = 0; ifa.IN_VALID = 0; ifa.IN_DATA = 8'h00;
        vq.delete();
    endtask

    initial begin
        ifa.IN_VALID = 0; ifa.IN_DATA = 8'h00;
        ifb.IN_VALID = 0; ifb.IN_DATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_a", a_out, 7'b0000000);
        chk("reset_b", b_out, 7'b0000000);
        #2 RST_N = 1'b1;

        add_full_load(7'b0000000, 1'b0);
        run_table("stream");

        add_full_load(7'b0000010, 1'b1);
        run_table("start_ignored");

        // Host starvation: IN_VALID low across the byte boundary, then a surplus byte offered.
        row(1, 0, 0, 8'h00, 7'b0000010);
        row(0, 0, 1, 8'hA5, 7'b0010100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1110100);
        for (int k = 0; k < 4; k++) row(0, 0, 0, 8'h00, 7'b0010100);
        row(0, 0, 1, 8'h03, 7'b0010100);
        row(0, 0, 1, 8'h5A, 7'b1100100);
        row(0, 0, 1, 8'h5A, 7'b1100100);
        row(0, 0, 1, 8'h5A, 7'b1000100);
        row(0, 0, 1, 8'h5A, 7'b1000100);
        row(0, 0, 1, 8'h5A, 7'b0001100);
        row(0, 0, 1, 8'h5A, 7'b0001100);
        row(0, 0, 1, 8'h5A, 7'b0000010);
        row(0, 0, 1, 8'h5A, 7'b0000010);
        run_table("starve");

        // Abort after six shifted bits, then a clean reload.
        row(1, 0, 0, 8'h00, 7'b0000010);
        row(0, 0, 1, 8'hA5, 7'b0010100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1000100);
        row(0, 0, 0, 8'h00, 7'b1100100);
        row(0, 1, 1, 8'h03, 7'b0000100);
        row(0, 0, 1, 8'h03, 7'b0000001);
        row(0, 1, 0, 8'h00, 7'b0000001);
        row(0, 0, 0, 8'h00, 7'b0000001);
        add_full_load(7'b0000001, 1'b0);
        run_table("abort");

        // Asynchronous reset between edges in the middle of a load.
        @(posedge CLK); #1 a_start = 1;
        @(posedge CLK); #1 a_start = 0; ifa.IN_VALID = 1; ifa.IN_DATA = 8'hA5;
        @(posedge CLK); #1 ifa.IN_VALID = 0;
        repeat (2) @(posedge CLK);
        #3;
        chk("pre_reset_shift", {6'd0, a_shift}, 7'd1);
        RST_N = 1'b0;
        #1;
        chk("async_reset_a", a_out, 7'b0000000);
        chk("async_reset_b", b_out, 7'b0000000);
        repeat (2) @(posedge CLK);
        #3 RST_N = 1'b1;
        ifa.IN_VALID = 1; ifa.IN_DATA = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("post_reset[%0d]", k), a_out, 7'b0000000);
            @(posedge CLK); #1;
        end
        a_start = 1;
        @(negedge CLK);
        chk("post_reset_start", a_out, 7'b0000000);
        @(posedge CLK); #1 a_start = 0;
        @(negedge CLK);
        chk("post_reset_ready", a_out, 7'b0010100);
        @(posedge CLK); #1 ifa.IN_VALID = 0; a_abort = 1;
        @(posedge CLK); #1 a_abort = 0;

        // Single-byte chain with a one-cycle latch strobe.
        b_start = 1;
        @(negedge CLK);
        chk("b_idle", b_out, 7'b0000000);
        @(posedge CLK); #1 b_start = 0; ifb.IN_VALID = 1; ifb.IN_DATA = 8'hFF;
        @(negedge CLK);
        chk("b_ready", b_out, 7'b0010100);
        @(posedge CLK); #1 ifb.IN_VALID = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            chk($sformatf("b_shift[%0d]", k), b_out, 7'b1100100);
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        chk("b_latch", b_out, 7'b0001100);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("b_done", b_out, 7'b0000010);
        @(posedge CLK); #1 b_abort = 1;
        @(negedge CLK);
        chk("b_abort_in_done", b_out, 7'b0000010);
        @(posedge CLK); #1 b_abort = 0;
        @(negedge CLK);
        chk("b_done_held", b_out, 7'b0000010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
